// File: rtl/pe_feeder.sv
// Sequencer for one PE column: weight bank plus pixel FIFO turned into a pe_in/pe_filter/mode/activate stream.
// Optional PE_FEEDER_STALL_CNT_EN adds a saturating stall_cnt output.
module pe_feeder #(
  parameter int DATA_W     = 8,
  parameter int KSIZE      = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wgt_valid,
  input  logic [DATA_W-1:0] wgt_data,
  output logic              wgt_ready,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  input  logic              start,
  input  logic              job_type,
  input  logic [7:0]        job_len,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] pe_in,
  output logic [DATA_W-1:0] pe_filter,
  output logic [1:0]        mode_o,
  output logic              activate,
  output logic              busy,
`ifdef PE_FEEDER_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              done
);

  localparam int WP_W  = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int CNT_W = (WP_W > 8) ? WP_W : 8;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOADW, RUN, DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] bank_q [KSIZE];
  logic [WP_W-1:0]   wptr_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [AW:0]       count_q;
  logic              job_type_q;
  logic [7:0]        job_len_q;
  logic [DATA_W-1:0] bias_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] pe_in_q, pe_filter_q;
  logic [1:0]        mode_q;
  logic              activate_q, done_q;

  logic push, pop, wgt_hs, accept, last_tap;

  assign wgt_ready = (state_q == IDLE);
  assign pix_ready = (count_q != FULL_CNT);
  assign push      = pix_valid && pix_ready;
  // No bypass: a freshly pushed pixel only becomes poppable once counted.
  assign pop       = (state_q == RUN) && (count_q != '0);
  assign wgt_hs    = wgt_valid && wgt_ready;
  assign accept    = (state_q == IDLE) && start;
  assign last_tap  = job_type_q ? (cnt_q == CNT_W'(job_len_q) - CNT_W'(1))
                                : (cnt_q == CNT_W'(KSIZE - 1));

  assign pe_in     = pe_in_q;
  assign pe_filter = pe_filter_q;
  assign mode_o    = mode_q;
  assign activate  = activate_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KSIZE; i++) bank_q[i] <= '0;
      wptr_q <= '0;
    end else begin
      if (wgt_hs) bank_q[wptr_q] <= wgt_data;
      if (accept)
        wptr_q <= '0;
      else if (wgt_hs)
        wptr_q <= (wptr_q == WP_W'(KSIZE - 1)) ? '0 : wptr_q + WP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= pix_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Outputs show the action of a state on the edge that leaves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      job_type_q  <= 1'b0;
      job_len_q   <= '0;
      bias_q      <= '0;
      cnt_q       <= '0;
      pe_in_q     <= '0;
      pe_filter_q <= '0;
      mode_q      <= 2'd3;
      activate_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            job_type_q <= job_type;
            job_len_q  <= job_len;
            bias_q     <= bias;
            cnt_q      <= '0;
            state_q    <= job_type ? LOADW : RUN;
          end
        end
        LOADW: begin
          mode_q      <= 2'd2;
          pe_filter_q <= bank_q[0];
          activate_q  <= 1'b0;
          state_q     <= (job_len_q == 8'd0) ? DONE : RUN;
        end
        RUN: begin
          if (pop) begin
            pe_in_q     <= fifo_mem[rd_ptr_q];
            pe_filter_q <= job_type_q ? bias_q : bank_q[cnt_q[WP_W-1:0]];
            mode_q      <= {1'b0, job_type_q};
            activate_q  <= 1'b1;
            cnt_q       <= cnt_q + CNT_W'(1);
            if (last_tap) state_q <= DONE;
          end else begin
            mode_q     <= 2'd3;
            activate_q <= 1'b0;
          end
        end
        default: begin
          done_q     <= 1'b1;
          mode_q     <= 2'd3;
          activate_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

`ifdef PE_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (accept)
      stall_cnt_q <= '0;
    else if (state_q == RUN && !pop && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: queue-based reference model compared every cycle, plus literal beat checks.
module tb_pe_feeder;
  localparam int DW = 8, K = 9, DEPTH = 16;

  logic clk = 0, rst = 1;
  logic wgt_valid = 0, pix_valid = 0, start = 0, job_type = 0;
  logic [DW-1:0] wgt_data = 0, pix_data = 0, bias = 0;
  logic [7:0] job_len = 0;
  logic [DW-1:0] pe_in, pe_filter;
  logic [1:0] mode_o;
  logic wgt_ready, pix_ready, activate, busy, done;
`ifdef PE_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pe_feeder #(.DATA_W(DW), .KSIZE(K), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wgt_valid(wgt_valid), .wgt_data(wgt_data), .wgt_ready(wgt_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .start(start), .job_type(job_type), .job_len(job_len), .bias(bias),
    .pe_in(pe_in), .pe_filter(pe_filter), .mode_o(mode_o), .activate(activate),
    .busy(busy),
`ifdef PE_FEEDER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .done(done));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: job phase 0 idle, 1 weight-load beat, 2 streaming, 3 finishing.
  int mq[$];
  int m_bank[K];
  int m_wptr, m_ph, m_jt, m_len, m_bias, m_taps, m_stall;
  int m_in, m_filt, m_mode, m_act, m_done;
  bit can_pop, can_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      for (int i = 0; i < K; i++) m_bank[i] = 0;
      m_wptr = 0; m_ph = 0; m_taps = 0; m_stall = 0;
      m_in = 0; m_filt = 0; m_mode = 3; m_act = 0; m_done = 0;
    end else begin
      can_pop  = (m_ph == 2) && (mq.size() > 0);
      can_push = pix_valid && (mq.size() < DEPTH);
      m_done = 0;
      case (m_ph)
        0: begin
          if (wgt_valid) begin
            m_bank[m_wptr] = int'(wgt_data);
            m_wptr = (m_wptr + 1) % K;
          end
          if (start) begin
            m_jt = int'(job_type); m_len = int'(job_len); m_bias = int'(bias);
            m_taps = 0; m_wptr = 0; m_stall = 0;
            m_ph = job_type ? 1 : 2;
          end
        end
        1: begin
          m_mode = 2; m_filt = m_bank[0]; m_act = 0;
          m_ph = (m_len == 0) ? 3 : 2;
        end
        2: begin
          if (can_pop) begin
            m_in = mq.pop_front();
            m_filt = (m_jt == 1) ? m_bias : m_bank[m_taps];
            m_mode = m_jt; m_act = 1;
            m_taps++;
            if (m_taps == ((m_jt == 1) ? m_len : K)) m_ph = 3;
          end else begin
            m_mode = 3; m_act = 0;
            if (m_stall < 65535) m_stall++;
          end
        end
        default: begin
          m_done = 1; m_mode = 3; m_act = 0; m_ph = 0;
        end
      endcase
      if (can_push) mq.push_back(int'(pix_data));
    end
  end

  always @(negedge clk) begin
    chk("pe_in", int'(pe_in), m_in);
    chk("pe_filter", int'(pe_filter), m_filt);
    chk("mode_o", int'(mode_o), m_mode);
    chk("activate", int'(activate), m_act);
    chk("done", int'(done), m_done);
    chk("busy", int'(busy), int'(m_ph != 0));
    chk("wgt_ready", int'(wgt_ready), int'(m_ph == 0));
    chk("pix_ready", int'(pix_ready), int'(mq.size() < DEPTH));
`ifdef PE_FEEDER_STALL_CNT_EN
    chk("stall_cnt", int'(stall_cnt), m_stall);
`endif
  end

  typedef struct {int m; int pin; int pf;} beat_t;
  beat_t blog[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (activate || mode_o == 2'd2) blog.push_back('{int'(mode_o), int'(pe_in), int'(pe_filter)});
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push_pix(input int v);
    pix_valid = 1; pix_data = DW'(v); tick(); pix_valid = 0;
  endtask

  task automatic load_w(input int v);
    wgt_valid = 1; wgt_data = DW'(v); tick(); wgt_valid = 0;
  endtask

  task automatic start_job(input int t, input int len, input int b);
    start = 1; job_type = t[0]; job_len = 8'(len); bias = DW'(b);
    tick(); start = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin tick(); n++; end
    chk("idle_timeout", int'(busy), 0);
    tick(); tick();
  endtask

  task automatic chk_beat(input string name, input int idx, input int m, input int pin, input int pf);
    if (idx >= blog.size()) begin
      chk({name, "_present"}, blog.size(), idx + 1);
    end else begin
      chk({name, "_mode"}, blog[idx].m, m);
      if (pin >= 0) chk({name, "_in"}, blog[idx].pin, pin);
      chk({name, "_filter"}, blog[idx].pf, pf);
    end
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    repeat (10) tick();
    chk("rst_mode", int'(mode_o), 3);
    chk("rst_act", int'(activate), 0);
    chk("rst_pix_ready", int'(pix_ready), 1);
    chk("rst_wgt_ready", int'(wgt_ready), 1);
    chk("rst_busy", int'(busy), 0);

    // MAC job, FIFO never empty
    for (int i = 1; i <= 9; i++) load_w(i);
    for (int i = 10; i <= 18; i++) push_pix(i);
    blog.delete(); done_cnt = 0;
    start_job(0, 0, 0);
    wait_idle();
    chk("mac_beats", blog.size(), 9);
    for (int i = 0; i < 9; i++) chk_beat("mac", i, 0, 10 + i, 1 + i);
    chk("mac_done_cnt", done_cnt, 1);

    // Stationary job
    load_w(7);
    push_pix(2); push_pix(3); push_pix(4);
    blog.delete(); done_cnt = 0;
    start_job(1, 3, 5);
    wait_idle();
    chk("stat_beats", blog.size(), 4);
    chk_beat("stat_load", 0, 2, -1, 7);
    for (int i = 0; i < 3; i++) chk_beat("stat", i + 1, 1, 2 + i, 5);
    chk("stat_done_cnt", done_cnt, 1);

    // MAC job with a starved FIFO
    for (int i = 1; i <= 9; i++) load_w(i);
    for (int i = 20; i <= 23; i++) push_pix(i);
    blog.delete(); done_cnt = 0;
    start_job(0, 0, 0);
    repeat (3) tick();
    for (int i = 24; i <= 28; i++) push_pix(i);
    wait_idle();
    chk("stall_beats", blog.size(), 9);
    for (int i = 0; i < 9; i++) chk_beat("stall", i, 0, 20 + i, 1 + i);

    // Fill FIFO, then run a job while pushes keep arriving
    for (int i = 30; i < 46; i++) push_pix(i);
    chk("full_ready", int'(pix_ready), 0);
    push_pix(99);
    blog.delete();
    pix_valid = 1; pix_data = 8'd50;
    start_job(0, 0, 0);
    wait_idle();
    pix_valid = 0;
    for (int i = 0; i < 9; i++) chk_beat("full", i, 0, 30 + i, 1 + i);

    // Reset in the middle of a MAC job
    blog.delete();
    start_job(0, 0, 0);
    begin
      int n = 0;
      while (blog.size() < 5 && n < 50) begin tick(); n++; end
      chk("tap5_reached", int'(blog.size() >= 5), 1);
    end
    rst = 1; tick();
    chk("mid_rst_in", int'(pe_in), 0);
    chk("mid_rst_filter", int'(pe_filter), 0);
    chk("mid_rst_mode", int'(mode_o), 3);
    chk("mid_rst_act", int'(activate), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_pix_ready", int'(pix_ready), 1);
    rst = 0; tick();
    blog.delete(); done_cnt = 0;
    start_job(1, 0, 9);
    wait_idle();
    chk("len0_beats", blog.size(), 1);
    chk_beat("len0_load", 0, 2, -1, 0);
    chk("len0_done_cnt", done_cnt, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      wgt_valid = ($urandom_range(0, 3) == 0);
      wgt_data  = DW'($urandom);
      pix_valid = $urandom_range(0, 1) == 1;
      pix_data  = DW'($urandom);
      start     = ($urandom_range(0, 7) == 0);
      job_type  = $urandom_range(0, 1) == 1;
      job_len   = 8'($urandom_range(0, 5));
      bias      = DW'($urandom);
      tick();
    end
    wgt_valid = 0; pix_valid = 0; start = 0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
